// File: rtl/audioport_pkg.sv
// Shared audio-port constants, command codes and the playback sequencer state type.
package audioport_pkg;

  localparam int AUDIO_BUFFER_SIZE = 32;

  // clk cycles per sample, assuming a 24.576 MHz system clock
  localparam int CLK_DIV_48000  = 512;
  localparam int CLK_DIV_96000  = 256;
  localparam int CLK_DIV_192000 = 128;

  localparam int STATUS_PLAY    = 0;
  localparam int STATUS_CLR_ERR = 1;
  localparam int STATUS_CFG_ERR = 2;
  localparam int STATUS_IRQ_ERR = 3;
  localparam int STATUS_CMD_ERR = 4;

  localparam logic [31:0] CMD_CLR    = 32'd1;
  localparam logic [31:0] CMD_CFG    = 32'd2;
  localparam logic [31:0] CMD_START  = 32'd4;
  localparam logic [31:0] CMD_STOP   = 32'd5;
  localparam logic [31:0] CMD_IRQACK = 32'd6;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_PLAY = 1'b1
  } seq_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Loadable down-counter producing a one-cycle tick every div_in clk cycles while enabled.
module sample_tick_gen #(
  parameter int DIV_BITS = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_in,
  input  logic                hold_in,
  input  logic                load_in,
  input  logic [DIV_BITS-1:0] div_in,
  output logic                tick_out
);

  logic [DIV_BITS-1:0] cnt_q, cnt_d;
  logic [DIV_BITS-1:0] reload_val;

  assign reload_val = div_in - DIV_BITS'(1);

  // The tick depends only on the registered count, so a hold in the tick cycle still lets it out.
  always_comb begin
    tick_out = en_in && (cnt_q == '0);
    cnt_d    = cnt_q;
    if (load_in) begin
      cnt_d = reload_val;
    end else if (en_in && !hold_in) begin
      cnt_d = tick_out ? reload_val : cnt_q - DIV_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/abuf_play_sequencer.sv
// Ping-pong audio buffer playback sequencer: sample tick, stereo read index, buffer swap and IRQ.
// Optional macro UNDERRUN_COUNT_EN adds underrun_cnt_out, a saturating count of missed buffers.
module abuf_play_sequencer #(
  parameter int AUDIO_BUFFER_SIZE = audioport_pkg::AUDIO_BUFFER_SIZE,
  parameter int DIV_BITS          = 32
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start_in,
  input  logic                                   stop_in,
  input  logic                                   clr_in,
  input  logic                                   cfg_in,
  input  logic                                   irqack_in,
  input  logic [DIV_BITS-1:0]                    clk_div_in,
  output logic                                   play_out,
  output logic                                   tick_out,
  output logic                                   abuf_sel_out,
  output logic [$clog2(2*AUDIO_BUFFER_SIZE)-1:0] abuf_word_out,
  output logic                                   irq_out,
  output logic                                   clr_err_out,
  output logic                                   cfg_err_out,
  output logic                                   irq_err_out,
  output logic                                   cmd_err_out
`ifdef UNDERRUN_COUNT_EN
  ,
  output logic [7:0]                             underrun_cnt_out
`endif
);

  import audioport_pkg::seq_state_t;
  import audioport_pkg::SEQ_IDLE;
  import audioport_pkg::SEQ_PLAY;
`ifdef UNDERRUN_COUNT_EN
  import audioport_pkg::sat_inc8;
`endif

  localparam int IDX_W  = $clog2(AUDIO_BUFFER_SIZE);
  localparam int WORD_W = $clog2(2*AUDIO_BUFFER_SIZE);

  seq_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             sel_q, sel_d;
  logic             irq_q, irq_d;
  logic             clr_err_q, clr_err_d;
  logic             cfg_err_q, cfg_err_d;
  logic             irq_err_q, irq_err_d;
  logic             cmd_err_q, cmd_err_d;
`ifdef UNDERRUN_COUNT_EN
  logic [7:0]       urun_q, urun_d;
`endif

  logic       tick, load, hold, irq_set;
  logic [2:0] strobe_cnt;
  logic       multi;
  logic       start_acc, stop_acc, clr_acc, cfg_acc, irqack_acc;

  // Commands arriving together are ambiguous, so none of them is acted on.
  assign strobe_cnt = 3'(start_in) + 3'(stop_in) + 3'(clr_in) + 3'(cfg_in) + 3'(irqack_in);
  assign multi      = strobe_cnt > 3'd1;
  assign start_acc  = start_in  && !multi;
  assign stop_acc   = stop_in   && !multi;
  assign clr_acc    = clr_in    && !multi;
  assign cfg_acc    = cfg_in    && !multi;
  assign irqack_acc = irqack_in && !multi;

  sample_tick_gen #(
    .DIV_BITS(DIV_BITS)
  ) u_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_in    (state_q == SEQ_PLAY),
    .hold_in  (hold),
    .load_in  (load),
    .div_in   (clk_div_in),
    .tick_out (tick)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sel_d     = sel_q;
    irq_d     = irq_q;
    clr_err_d = clr_err_q;
    cfg_err_d = cfg_err_q;
    irq_err_d = irq_err_q;
    cmd_err_d = cmd_err_q;
`ifdef UNDERRUN_COUNT_EN
    urun_d    = urun_q;
`endif
    load      = 1'b0;
    hold      = 1'b0;
    irq_set   = 1'b0;

    if (multi)      cmd_err_d = 1'b1;
    if (irqack_acc) irq_d     = 1'b0;

    case (state_q)
      SEQ_IDLE: begin
        if (start_acc) begin
          state_d = SEQ_PLAY;
          load    = 1'b1;
          idx_d   = '0;
          sel_d   = 1'b0;
        end
        if (clr_acc) begin
          clr_err_d = 1'b0;
          cfg_err_d = 1'b0;
          irq_err_d = 1'b0;
          cmd_err_d = 1'b0;
          irq_d     = 1'b0;
          idx_d     = '0;
          sel_d     = 1'b0;
`ifdef UNDERRUN_COUNT_EN
          urun_d    = '0;
`endif
        end
      end
      SEQ_PLAY: begin
        if (start_acc) cmd_err_d = 1'b1;
        if (clr_acc)   clr_err_d = 1'b1;
        if (cfg_acc)   cfg_err_d = 1'b1;
        if (stop_acc) begin
          state_d = SEQ_IDLE;
          hold    = 1'b1;
        end
        // A tick coinciding with stop still advances the index and may swap buffers.
        if (tick) begin
          if (idx_q == IDX_W'(AUDIO_BUFFER_SIZE-1)) begin
            idx_d   = '0;
            sel_d   = !sel_q;
            irq_set = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = SEQ_IDLE;
    endcase

    // Applied last so a buffer-drained set beats a same-cycle acknowledge.
    if (irq_set) begin
      irq_d = 1'b1;
      if (irq_q) begin
        irq_err_d = 1'b1;
`ifdef UNDERRUN_COUNT_EN
        urun_d    = sat_inc8(urun_q);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= SEQ_IDLE;
      idx_q     <= '0;
      sel_q     <= 1'b0;
      irq_q     <= 1'b0;
      clr_err_q <= 1'b0;
      cfg_err_q <= 1'b0;
      irq_err_q <= 1'b0;
      cmd_err_q <= 1'b0;
`ifdef UNDERRUN_COUNT_EN
      urun_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sel_q     <= sel_d;
      irq_q     <= irq_d;
      clr_err_q <= clr_err_d;
      cfg_err_q <= cfg_err_d;
      irq_err_q <= irq_err_d;
      cmd_err_q <= cmd_err_d;
`ifdef UNDERRUN_COUNT_EN
      urun_q    <= urun_d;
`endif
    end
  end

  assign play_out      = (state_q == SEQ_PLAY);
  assign tick_out      = tick;
  assign abuf_sel_out  = sel_q;
  assign abuf_word_out = WORD_W'({idx_q, 1'b0});
  assign irq_out       = irq_q;
  assign clr_err_out   = clr_err_q;
  assign cfg_err_out   = cfg_err_q;
  assign irq_err_out   = irq_err_q;
  assign cmd_err_out   = cmd_err_q;
`ifdef UNDERRUN_COUNT_EN
  assign underrun_cnt_out = urun_q;
`endif

endmodule

// File: tb/tb_abuf_play_sequencer.sv
// Self-checking bench for abuf_play_sequencer; define UNDERRUN_COUNT_EN to cover the underrun counter.
module tb_abuf_play_sequencer;
  import audioport_pkg::*;

  localparam int N           = 32;
  localparam int WORD_W      = 6;
  localparam int DIV_BITS    = 32;
  localparam int TICK_BUDGET = 2000;

  logic                clk;
  logic                rst_n;
  logic                start_in, stop_in, clr_in, cfg_in, irqack_in;
  logic [DIV_BITS-1:0] clk_div_in;
  logic                play_out, tick_out, abuf_sel_out, irq_out;
  logic [WORD_W-1:0]   abuf_word_out;
  logic                clr_err_out, cfg_err_out, irq_err_out, cmd_err_out;
`ifdef UNDERRUN_COUNT_EN
  logic [7:0]          underrun_cnt_out;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard entries are {abuf_sel, abuf_word} expected at each tick.
  logic [WORD_W:0] exp_q[$];
  int              exp_idx;
  logic            exp_sel;

  abuf_play_sequencer #(
    .AUDIO_BUFFER_SIZE(N),
    .DIV_BITS(DIV_BITS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_in      (start_in),
    .stop_in       (stop_in),
    .clr_in        (clr_in),
    .cfg_in        (cfg_in),
    .irqack_in     (irqack_in),
    .clk_div_in    (clk_div_in),
    .play_out      (play_out),
    .tick_out      (tick_out),
    .abuf_sel_out  (abuf_sel_out),
    .abuf_word_out (abuf_word_out),
    .irq_out       (irq_out),
    .clr_err_out   (clr_err_out),
    .cfg_err_out   (cfg_err_out),
    .irq_err_out   (irq_err_out),
    .cmd_err_out   (cmd_err_out)
`ifdef UNDERRUN_COUNT_EN
    ,
    .underrun_cnt_out (underrun_cnt_out)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic clear_strobes();
    start_in  = 1'b0;
    stop_in   = 1'b0;
    clr_in    = 1'b0;
    cfg_in    = 1'b0;
    irqack_in = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    clear_strobes();
  endtask

  task automatic wait_tick(output int cycles);
    cycles = -1;
    for (int c = 1; c <= TICK_BUDGET; c++) begin
      step();
      if (tick_out === 1'b1) begin
        cycles = c;
        break;
      end
    end
  endtask

  task automatic model_push(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({exp_sel, WORD_W'(2*exp_idx)});
      if (exp_idx == N-1) begin
        exp_idx = 0;
        exp_sel = ~exp_sel;
      end else begin
        exp_idx++;
      end
    end
  endtask

  task automatic start_play(input int div);
    clk_div_in = DIV_BITS'(div);
    start_in   = 1'b1;
    exp_idx    = 0;
    exp_sel    = 1'b0;
    exp_q.delete();
  endtask

  // act: 0 none, 1 irqack, 2 stop -- driven into the cycle of the final tick
  task automatic run_ticks(input int n, input int div, input bit chk_iv, input int act);
    int c;
    logic [WORD_W:0] e, got;
    model_push(n);
    for (int i = 0; i < n; i++) begin
      wait_tick(c);
      n_cmp++;
      if (c < 0) begin
        n_err++;
        $display("FAIL tick_timeout: no tick within %0d cycles, tick %0d of %0d", TICK_BUDGET, i, n);
        exp_q.delete();
        return;
      end
      if (chk_iv) begin
        n_cmp++;
        if (c != div) begin
          n_err++;
          $display("FAIL tick_interval: got %0d cycles, expected %0d", c, div);
        end
      end
      got = {abuf_sel_out, abuf_word_out};
      e   = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL tick_index: got sel/word %0h, expected %0h", got, e);
      end
    end
    if (act == 1) irqack_in = 1'b1;
    if (act == 2) stop_in   = 1'b1;
  endtask

  // scenario tasks
  task automatic test_reset();
    rst_n = 1'b0;
    clear_strobes();
    clk_div_in = DIV_BITS'(64);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    n_cmp++; if (play_out !== 1'b0) begin n_err++; $display("FAIL reset_play: got %b expected 0", play_out); end
    n_cmp++; if (tick_out !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %b expected 0", tick_out); end
    n_cmp++; if (abuf_sel_out !== 1'b0) begin n_err++; $display("FAIL reset_sel: got %b expected 0", abuf_sel_out); end
    n_cmp++; if (abuf_word_out !== '0) begin n_err++; $display("FAIL reset_word: got %0d expected 0", abuf_word_out); end
    n_cmp++; if (irq_out !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b expected 0", irq_out); end
    n_cmp++;
    if ({clr_err_out, cfg_err_out, irq_err_out, cmd_err_out} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_errs: got %b expected 0000", {clr_err_out, cfg_err_out, irq_err_out, cmd_err_out});
    end
  endtask

  task automatic test_first_buffer();
    start_play(64);
    run_ticks(N, 64, 1'b1, 0);
    step();
    n_cmp++; if (play_out !== 1'b1) begin n_err++; $display("FAIL play_status: got %b expected 1", play_out); end
    n_cmp++; if (abuf_sel_out !== 1'b1) begin n_err++; $display("FAIL swap_sel: got %b expected 1", abuf_sel_out); end
    n_cmp++; if (abuf_word_out !== '0) begin n_err++; $display("FAIL swap_word: got %0d expected 0", abuf_word_out); end
    n_cmp++; if (irq_out !== 1'b1) begin n_err++; $display("FAIL swap_irq: got %b expected 1", irq_out); end
    irqack_in = 1'b1;
    step();
    n_cmp++; if (irq_out !== 1'b0) begin n_err++; $display("FAIL irqack: got %b expected 0", irq_out); end
  endtask

  task automatic test_irq_err();
    clk_div_in = DIV_BITS'(4);
    run_ticks(N, 4, 1'b0, 0);
    step();
    n_cmp++; if (irq_out !== 1'b1) begin n_err++; $display("FAIL irq_second: got %b expected 1", irq_out); end
    n_cmp++; if (irq_err_out !== 1'b0) begin n_err++; $display("FAIL irq_err_early: got %b expected 0", irq_err_out); end
    run_ticks(N, 4, 1'b0, 0);
    step();
    n_cmp++; if (irq_err_out !== 1'b1) begin n_err++; $display("FAIL irq_err_set: got %b expected 1", irq_err_out); end
    n_cmp++; if (abuf_sel_out !== exp_sel) begin n_err++; $display("FAIL irq_err_sel: got %b expected %b", abuf_sel_out, exp_sel); end
  endtask

  task automatic test_cmd_err();
    clr_in = 1'b1;
    step();
    n_cmp++; if (clr_err_out !== 1'b1) begin n_err++; $display("FAIL clr_in_play: got %b expected 1", clr_err_out); end
    n_cmp++; if (irq_out !== 1'b1) begin n_err++; $display("FAIL clr_ignored_irq: got %b expected 1", irq_out); end
    cfg_in = 1'b1;
    step();
    n_cmp++; if (cfg_err_out !== 1'b1) begin n_err++; $display("FAIL cfg_in_play: got %b expected 1", cfg_err_out); end
    start_in = 1'b1;
    step();
    n_cmp++; if (cmd_err_out !== 1'b1) begin n_err++; $display("FAIL start_in_play: got %b expected 1", cmd_err_out); end
    n_cmp++; if (play_out !== 1'b1) begin n_err++; $display("FAIL still_playing: got %b expected 1", play_out); end
    stop_in = 1'b1;
    step();
    n_cmp++; if (play_out !== 1'b0) begin n_err++; $display("FAIL stop: got %b expected 0", play_out); end
    n_cmp++; if (clr_err_out !== 1'b1) begin n_err++; $display("FAIL clr_err_sticky: got %b expected 1", clr_err_out); end
    clr_in = 1'b1;
    step();
    n_cmp++;
    if ({clr_err_out, cfg_err_out, irq_err_out, cmd_err_out} !== 4'b0) begin
      n_err++;
      $display("FAIL clr_errs: got %b expected 0000", {clr_err_out, cfg_err_out, irq_err_out, cmd_err_out});
    end
    n_cmp++;
    if ({irq_out, abuf_sel_out, abuf_word_out} !== '0) begin
      n_err++;
      $display("FAIL clr_state: got irq/sel/word %b/%b/%0d expected 0/0/0", irq_out, abuf_sel_out, abuf_word_out);
    end
    start_in = 1'b1;
    cfg_in   = 1'b1;
    step();
    n_cmp++; if (play_out !== 1'b0) begin n_err++; $display("FAIL multi_ignored: got play %b expected 0", play_out); end
    n_cmp++; if (cmd_err_out !== 1'b1) begin n_err++; $display("FAIL multi_cmd_err: got %b expected 1", cmd_err_out); end
    clr_in = 1'b1;
    step();
    n_cmp++; if (cmd_err_out !== 1'b0) begin n_err++; $display("FAIL multi_clr: got %b expected 0", cmd_err_out); end
  endtask

  task automatic test_boundary_collisions();
    int ticks;
    start_play(4);
    run_ticks(N, 4, 1'b1, 0);
    run_ticks(N, 4, 1'b1, 1);
    step();
    n_cmp++; if (irq_out !== 1'b1) begin n_err++; $display("FAIL ack_vs_set: got %b expected 1", irq_out); end
    n_cmp++; if (abuf_sel_out !== exp_sel) begin n_err++; $display("FAIL ack_vs_set_sel: got %b expected %b", abuf_sel_out, exp_sel); end
    run_ticks(N, 4, 1'b0, 2);
    step();
    n_cmp++; if (play_out !== 1'b0) begin n_err++; $display("FAIL stop_on_tick_play: got %b expected 0", play_out); end
    n_cmp++; if (abuf_sel_out !== exp_sel) begin n_err++; $display("FAIL stop_on_tick_sel: got %b expected %b", abuf_sel_out, exp_sel); end
    n_cmp++; if (abuf_word_out !== '0) begin n_err++; $display("FAIL stop_on_tick_word: got %0d expected 0", abuf_word_out); end
    n_cmp++; if (irq_out !== 1'b1) begin n_err++; $display("FAIL stop_on_tick_irq: got %b expected 1", irq_out); end
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tick_out === 1'b1) ticks++;
    end
    n_cmp++; if (ticks != 0) begin n_err++; $display("FAIL ticks_after_stop: got %0d expected 0", ticks); end
  endtask

  task automatic test_reset_mid_play();
    int ticks;
    start_play(4);
    run_ticks(3, 4, 1'b1, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++;
    if ({play_out, tick_out, abuf_sel_out, abuf_word_out, irq_out} !== '0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: got play/tick/sel/word/irq %b/%b/%b/%0d/%b expected all 0",
               play_out, tick_out, abuf_sel_out, abuf_word_out, irq_out);
    end
    n_cmp++;
    if ({clr_err_out, cfg_err_out, irq_err_out, cmd_err_out} !== 4'b0) begin
      n_err++;
      $display("FAIL rst_mid_errs: got %b expected 0000", {clr_err_out, cfg_err_out, irq_err_out, cmd_err_out});
    end
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tick_out === 1'b1) ticks++;
    end
    n_cmp++; if (ticks != 0) begin n_err++; $display("FAIL ticks_after_rst: got %0d expected 0", ticks); end
  endtask

  task automatic test_div_change();
    int c;
    logic [WORD_W:0] e, got;
    start_play(CLK_DIV_48000);
    run_ticks(1, CLK_DIV_48000, 1'b1, 0);
    model_push(1);
    step();
    clk_div_in = DIV_BITS'(CLK_DIV_192000);
    wait_tick(c);
    n_cmp++;
    if (c < 0 || c + 1 != CLK_DIV_48000) begin
      n_err++;
      $display("FAIL div_old_reload: got %0d cycles expected %0d", c + 1, CLK_DIV_48000);
    end
    got = {abuf_sel_out, abuf_word_out};
    e   = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL div_change_index: got %0h expected %0h", got, e);
    end
    run_ticks(2, CLK_DIV_192000, 1'b1, 0);
  endtask

`ifdef UNDERRUN_COUNT_EN
  task automatic test_underrun();
    stop_in = 1'b1;
    step();
    clr_in = 1'b1;
    step();
    n_cmp++; if (underrun_cnt_out !== 8'd0) begin n_err++; $display("FAIL urun_clr: got %0d expected 0", underrun_cnt_out); end
    start_play(2);
    run_ticks(2*N, 2, 1'b0, 0);
    step();
    n_cmp++; if (underrun_cnt_out !== 8'd1) begin n_err++; $display("FAIL urun_one: got %0d expected 1", underrun_cnt_out); end
    run_ticks(299*N, 2, 1'b0, 0);
    step();
    n_cmp++; if (underrun_cnt_out !== 8'd255) begin n_err++; $display("FAIL urun_sat: got %0d expected 255", underrun_cnt_out); end
  endtask
`endif

  initial begin
    test_reset();
    test_first_buffer();
    test_irq_err();
    test_cmd_err();
    test_boundary_collisions();
    test_reset_mid_play();
    test_div_change();
`ifdef UNDERRUN_COUNT_EN
    test_underrun();
`endif
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
